branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequencer for the branch comparator in the pipelined RV32 core. It accepts one branch at a time from the ID stage and holds ID stalled until both source operands are ready. It then drives the embedded `cmp_32` with registered operands and a compare code, and issues a one-cycle redirect/flush to IF/ID when the branch is taken. It also keeps saturating branch and taken-branch counters for performance readout.

## Interface
Parameters:
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `kill`  in  1  abort from an older instruction (exception or flush); has priority over everything else.
- `br_valid`  in  1  ID presents a branch.
- `br_ready`  out  1  block can accept a branch; high only in IDLE.
- `br_ctrl`  in  3  compare code: 001 EQ, 010 NE, 011 LT, 100 LTU, 101 GE, 110 GEU. Codes 000 and 111 mean an unconditional jump (always taken).
- `br_target`  in  32  target PC, computed upstream.
- `rs1_rdy`, `rs2_rdy`  in  1 each  operand valid, from the hazard/forwarding unit.
- `rs1_data`, `rs2_data`  in  32 each  forwarded operand values.
- `stall_id`  out  1  freeze the ID stage.
- `resolve_done`  out  1  one-cycle pulse when the outcome is known.
- `taken`  out  1  outcome; valid only while `resolve_done` is high, otherwise 0.
- `redirect`  out  1  one-cycle pulse: IF loads `redirect_pc`.
- `flush`  out  1  kill IF/ID contents; identical timing to `redirect`.
- `redirect_pc`  out  32  registered target.
- `branch_cnt`  out  CNT_W  resolved branches, saturating.
- `taken_cnt`  out  CNT_W  taken branches, saturating.

## Operation
- FSM states: IDLE, WAIT, EVAL, REDIR.
- **IDLE:**
  - `br_ready`=1.
  - On `br_valid` with `kill`=0: latch `br_ctrl` into ctrl_q and `br_target` into tgt_q, then go to WAIT.
- **WAIT:**
  - `stall_id`=1.
  - When `rs1_rdy & rs2_rdy`: latch `rs1_data` and `rs2_data` into opa_q and opb_q, then go to EVAL. Otherwise stay in WAIT, with no timeout.
- **EVAL:**
  - `stall_id`=1 and `resolve_done`=1.
  - `cmp_32` is driven from opa_q, opb_q and ctrl_q.
  - `taken` = cmp result, or 1 if ctrl_q is 000 or 111.
  - Counters update on the EVAL exit edge.
  - Next state: REDIR if taken, else IDLE.
- **REDIR:**
  - `redirect`=1 and `flush`=1.
  - `redirect_pc`=tgt_q (the register is loaded on EVAL exit).
  - `stall_id`=0.
  - Next state: IDLE.
- **kill:** from any state, the next state is IDLE. No redirect is issued, no counter updates, and the latched data is discarded. A `kill` arriving during REDIR does not shorten that cycle's pulse, which has already been issued.
- **Counters:** +1 per EVAL exit. Each holds at 2^CNT_W−1 once it reaches that value, with no wrap. `taken_cnt` increments only when taken.
- **Compare semantics:**
  - LT and GE are two's-complement signed; LTU and GEU are unsigned.
  - Example: 0x80000000 LT 0x00000001 = 1, while 0x80000000 LTU 0x00000001 = 0.

## Timing
- **Reset values:** state=IDLE, `br_ready`=1. All other outputs are 0, including `redirect_pc`=0 and both counters=0.
- **Latency:** with a branch accepted at edge N and operands ready in cycle N+1:
  - EVAL in cycle N+2.
  - REDIR pulse in cycle N+3 if taken.
  - Back in IDLE, accepting a new branch, at cycle N+3 if not-taken or N+4 if taken.
- Each cycle of operand unreadiness adds exactly one cycle.
- `br_ready` is combinational from state only and never depends on `br_valid`.
- Outputs are Moore-style from state and registers. `redirect`, `flush` and `resolve_done` are never high for two consecutive cycles for the same branch.
- Reset asserted mid-operation forces IDLE asynchronously. Any pending redirect is lost.

## Test plan
- BEQ, opa=opb=0x12345678, both ready immediately → `resolve_done`=1 and `taken`=1 at N+2; `redirect`=1 with `redirect_pc`=`br_target` (0x00000100) at N+3; `branch_cnt`=1, `taken_cnt`=1.
- BLT vs BLTU with opa=0xFFFFFFFF, opb=0x00000001 → BLT taken (redirect pulse); BLTU not taken (no redirect, `br_ready`=1 at N+3).
- BNE with `rs2_rdy` low for 3 cycles → `stall_id` high the whole time, EVAL 3 cycles later than the base case, exactly one `resolve_done` pulse.
- `kill` asserted in WAIT, and separately in EVAL → IDLE next cycle, no `redirect`, counters unchanged. `kill` together with `br_valid` in IDLE → branch not accepted.
- `br_ctrl`=000 with opa≠opb → taken and redirect issued. Back-to-back branches with `br_valid` held → the second is accepted only when `br_ready`=1.
- CNT_W=2, 5 taken branches → both counters hold at 3. `rstn` pulsed low mid-WAIT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: holds ID until operands are ready, evaluates the
// branch through cmp_32, issues a one-cycle redirect/flush when taken, counts outcomes.

module cmp_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctrl,
    output logic        result
);

    // Compare-code decode; jump codes (000/111) yield 0 here and are handled by the caller
    always_comb begin
        result = 1'b0;
        case (ctrl)
            3'b001:  result = (a == b);
            3'b010:  result = (a != b);
            3'b011:  result = ($signed(a) <  $signed(b));
            3'b100:  result = (a <  b);
            3'b101:  result = ($signed(a) >= $signed(b));
            3'b110:  result = (a >= b);
            default: result = 1'b0;
        endcase
    end

endmodule

module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             kill,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_ctrl,
    input  logic [31:0]      br_target,
    input  logic             rs1_rdy,
    input  logic             rs2_rdy,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             stall_id,
    output logic             resolve_done,
    output logic             taken,
    output logic             redirect,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [2:0]       ctrl_r;
    logic [31:0]      tgt_r;
    logic [31:0]      opa_r;
    logic [31:0]      opb_r;
    logic [31:0]      redir_pc_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    logic             cmp_res_s;
    logic             uncond_s;
    logic             taken_s;

    cmp_32 u_cmp (
        .a      (opa_r),
        .b      (opb_r),
        .ctrl   (ctrl_r),
        .result (cmp_res_s)
    );

    assign uncond_s = (ctrl_r == 3'b000) || (ctrl_r == 3'b111);
    assign taken_s  = cmp_res_s | uncond_s;

    // Sequencer state, latched branch data, redirect target and saturating counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            ctrl_r       <= 3'b000;
            tgt_r        <= 32'h0000_0000;
            opa_r        <= 32'h0000_0000;
            opb_r        <= 32'h0000_0000;
            redir_pc_r   <= 32'h0000_0000;
            branch_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r  <= {CNT_W{1'b0}};
        end else if (kill) begin
            // Abort drops the in-flight branch without touching counters or the redirect target
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (br_valid) begin
                        ctrl_r  <= br_ctrl;
                        tgt_r   <= br_target;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (rs1_rdy && rs2_rdy) begin
                        opa_r   <= rs1_data;
                        opb_r   <= rs2_data;
                        state_r <= ST_EVAL;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_EVAL: begin
                    redir_pc_r <= tgt_r;
                    if (branch_cnt_r != CNT_MAX) begin
                        branch_cnt_r <= branch_cnt_r + CNT_ONE;
                    end else begin
                        branch_cnt_r <= branch_cnt_r;
                    end
                    if (taken_s) begin
                        if (taken_cnt_r != CNT_MAX) begin
                            taken_cnt_r <= taken_cnt_r + CNT_ONE;
                        end else begin
                            taken_cnt_r <= taken_cnt_r;
                        end
                        state_r <= ST_REDIR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from state and registered data
    always_comb begin
        br_ready     = 1'b0;
        stall_id     = 1'b0;
        resolve_done = 1'b0;
        taken        = 1'b0;
        redirect     = 1'b0;
        flush        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                br_ready = 1'b1;
            end
            ST_WAIT: begin
                stall_id = 1'b1;
            end
            ST_EVAL: begin
                stall_id     = 1'b1;
                resolve_done = 1'b1;
                taken        = taken_s;
            end
            ST_REDIR: begin
                redirect = 1'b1;
                flush    = 1'b1;
            end
            default: begin
                br_ready = 1'b0;
            end
        endcase
    end

    assign redirect_pc = redir_pc_r;
    assign branch_cnt  = branch_cnt_r;
    assign taken_cnt   = taken_cnt_r;

endmodule
